// File: rtl/ama_riscv_result_pipe.sv
// Result pipeline: carries destination info and results from EXE through MEM to WBK,
// serves forwarded operands and drives the register-file write port(s).

package ama_riscv_result_pipe_pkg;
  localparam int unsigned RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [1:0] fwd_be_t;

  localparam rf_addr_t RF_X0_ZERO = '0;

  // fwd_be_t is {rdp, wbk}
  localparam fwd_be_t FWD_MEM_D = 2'b00;
  localparam fwd_be_t FWD_WBK_D = 2'b01;
  localparam fwd_be_t FWD_MEM_P = 2'b10;
  localparam fwd_be_t FWD_WBK_P = 2'b11;

  // Paired destination; the forwarding unit calls this same function
  function automatic rf_addr_t get_rdp(input rf_addr_t rd);
    return {rd[RF_ADDR_W-1:1], 1'b1};
  endfunction
endpackage

module ama_riscv_result_pipe
  import ama_riscv_result_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush_exe,
  input  logic            bubble_exe,
  input  rf_addr_t        rd_exe,
  input  logic            rd_we_exe,
  input  logic            rdp_we_exe,
  input  logic            load_inst_exe,
  input  logic            mult_inst_exe,
  input  logic [XLEN-1:0] res_exe,
  input  logic [XLEN-1:0] resp_exe,
  input  logic [XLEN-1:0] late_res_mem,
  input  logic [XLEN-1:0] late_resp_mem,
  input  logic            late_valid_mem,
  input  fwd_be_t         fwd_be_rs1_exe,
  input  fwd_be_t         fwd_be_rs2_exe,
  input  fwd_be_t         fwd_be_rs1_dec,
  input  fwd_be_t         fwd_be_rs2_dec,
  output rf_addr_t        rd_mem,
  output rf_addr_t        rd_wbk,
  output logic            rd_we_mem,
  output logic            rdp_we_mem,
  output logic            rd_we_wbk,
  output logic            rdp_we_wbk,
  output logic            load_inst_mem,
  output logic            mult_inst_mem,
  output logic [XLEN-1:0] fwd_rs1_exe,
  output logic [XLEN-1:0] fwd_rs2_exe,
  output logic [XLEN-1:0] fwd_rs1_dec,
  output logic [XLEN-1:0] fwd_rs2_dec,
  output logic            rf_we,
  output logic            rfp_we,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] rfp_wdata,
  output logic            late_wait
);

  rf_addr_t        mem_rd;
  logic            mem_rd_we;
  logic            mem_rdp_we;
  logic            mem_load;
  logic            mem_mult;
  logic [XLEN-1:0] mem_res;
  logic [XLEN-1:0] mem_resp;

  rf_addr_t        wbk_rd;
  logic            wbk_rd_we;
  logic            wbk_rdp_we;
  logic [XLEN-1:0] wbk_data;
  logic [XLEN-1:0] wbk_pdata;

  logic            mem_two_cycle;
  logic [XLEN-1:0] mem_data_eff;
  logic [XLEN-1:0] mem_pdata_eff;
  logic            adv;
  logic            kill_exe;

  // Effective MEM result: 2-cycle instructions take their words from the late inputs
  always_comb begin
    mem_two_cycle = mem_load | mem_mult;
    mem_data_eff  = mem_two_cycle ? late_res_mem  : mem_res;
    mem_pdata_eff = mem_two_cycle ? late_resp_mem : mem_resp;
  end

  assign late_wait = mem_two_cycle & ~late_valid_mem;
  assign adv       = ~stall & ~late_wait;
  assign kill_exe  = flush_exe | bubble_exe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd     <= '0;
      mem_rd_we  <= 1'b0;
      mem_rdp_we <= 1'b0;
      mem_load   <= 1'b0;
      mem_mult   <= 1'b0;
      mem_res    <= '0;
      mem_resp   <= '0;
    end else if (adv) begin
      if (kill_exe) begin
        mem_rd     <= '0;
        mem_rd_we  <= 1'b0;
        mem_rdp_we <= 1'b0;
        mem_load   <= 1'b0;
        mem_mult   <= 1'b0;
        mem_res    <= '0;
        mem_resp   <= '0;
      end else begin
        mem_rd     <= rd_exe;
        mem_rd_we  <= rd_we_exe;
        mem_rdp_we <= rdp_we_exe;
        mem_load   <= load_inst_exe;
        mem_mult   <= mult_inst_exe;
        mem_res    <= res_exe;
        mem_resp   <= resp_exe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbk_rd     <= '0;
      wbk_rd_we  <= 1'b0;
      wbk_rdp_we <= 1'b0;
      wbk_data   <= '0;
      wbk_pdata  <= '0;
    end else if (adv) begin
      wbk_rd     <= mem_rd;
      wbk_rd_we  <= mem_rd_we;
      wbk_rdp_we <= mem_rdp_we;
      wbk_data   <= mem_data_eff;
      wbk_pdata  <= mem_pdata_eff;
    end
  end

  function automatic logic [XLEN-1:0] fwd_exe_mux(
    input fwd_be_t         sel,
    input logic [XLEN-1:0] m_d,
    input logic [XLEN-1:0] m_p,
    input logic [XLEN-1:0] w_d,
    input logic [XLEN-1:0] w_p
  );
    logic [XLEN-1:0] r;
    case (sel)
      FWD_MEM_D: r = m_d;
      FWD_WBK_D: r = w_d;
      FWD_MEM_P: r = m_p;
      FWD_WBK_P: r = w_p;
      default:   r = m_d;
    endcase
    return r;
  endfunction

  // DEC always reads WBK; only the rdp bit matters
  always_comb begin
    fwd_rs1_exe = fwd_exe_mux(fwd_be_rs1_exe, mem_data_eff, mem_pdata_eff, wbk_data, wbk_pdata);
    fwd_rs2_exe = fwd_exe_mux(fwd_be_rs2_exe, mem_data_eff, mem_pdata_eff, wbk_data, wbk_pdata);
    fwd_rs1_dec = fwd_be_rs1_dec[1] ? wbk_pdata : wbk_data;
    fwd_rs2_dec = fwd_be_rs2_dec[1] ? wbk_pdata : wbk_data;
  end

  assign rd_mem        = mem_rd;
  assign rd_we_mem     = mem_rd_we;
  assign rdp_we_mem    = mem_rdp_we;
  assign load_inst_mem = mem_load;
  assign mult_inst_mem = mem_mult;

  assign rd_wbk     = wbk_rd;
  assign rd_we_wbk  = wbk_rd_we;
  assign rdp_we_wbk = wbk_rdp_we;

  // A held WBK keeps re-asserting the same write, which is harmless
  assign rf_we     = wbk_rd_we & (wbk_rd != RF_X0_ZERO);
  assign rfp_we    = wbk_rdp_we;
  assign rf_wdata  = wbk_data;
  assign rfp_wdata = wbk_pdata;

endmodule

// File: tb/tb_ama_riscv_result_pipe.sv
// Self-checking bench for ama_riscv_result_pipe: directed table, corner sequences,
// then randomized traffic against an instruction-level reference model.
module tb_ama_riscv_result_pipe;
  import ama_riscv_result_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush_exe, bubble_exe;
  rf_addr_t rd_exe;
  logic rd_we_exe, rdp_we_exe, load_inst_exe, mult_inst_exe;
  logic [31:0] res_exe, resp_exe, late_res_mem, late_resp_mem;
  logic late_valid_mem;
  fwd_be_t fwd_be_rs1_exe, fwd_be_rs2_exe, fwd_be_rs1_dec, fwd_be_rs2_dec;
  rf_addr_t rd_mem, rd_wbk;
  logic rd_we_mem, rdp_we_mem, rd_we_wbk, rdp_we_wbk, load_inst_mem, mult_inst_mem;
  logic [31:0] fwd_rs1_exe, fwd_rs2_exe, fwd_rs1_dec, fwd_rs2_dec;
  logic rf_we, rfp_we;
  logic [31:0] rf_wdata, rfp_wdata;
  logic late_wait;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ama_riscv_result_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush_exe(flush_exe), .bubble_exe(bubble_exe),
    .rd_exe(rd_exe), .rd_we_exe(rd_we_exe), .rdp_we_exe(rdp_we_exe),
    .load_inst_exe(load_inst_exe), .mult_inst_exe(mult_inst_exe),
    .res_exe(res_exe), .resp_exe(resp_exe),
    .late_res_mem(late_res_mem), .late_resp_mem(late_resp_mem), .late_valid_mem(late_valid_mem),
    .fwd_be_rs1_exe(fwd_be_rs1_exe), .fwd_be_rs2_exe(fwd_be_rs2_exe),
    .fwd_be_rs1_dec(fwd_be_rs1_dec), .fwd_be_rs2_dec(fwd_be_rs2_dec),
    .rd_mem(rd_mem), .rd_wbk(rd_wbk), .rd_we_mem(rd_we_mem), .rdp_we_mem(rdp_we_mem),
    .rd_we_wbk(rd_we_wbk), .rdp_we_wbk(rdp_we_wbk),
    .load_inst_mem(load_inst_mem), .mult_inst_mem(mult_inst_mem),
    .fwd_rs1_exe(fwd_rs1_exe), .fwd_rs2_exe(fwd_rs2_exe),
    .fwd_rs1_dec(fwd_rs1_dec), .fwd_rs2_dec(fwd_rs2_dec),
    .rf_we(rf_we), .rfp_we(rfp_we), .rf_wdata(rf_wdata), .rfp_wdata(rfp_wdata),
    .late_wait(late_wait)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_exe(input logic [4:0] rd, input logic we, input logic pwe,
                         input logic ld, input logic ml,
                         input logic [31:0] res, input logic [31:0] resp);
    rd_exe = rd; rd_we_exe = we; rdp_we_exe = pwe;
    load_inst_exe = ld; mult_inst_exe = ml; res_exe = res; resp_exe = resp;
  endtask

  task automatic set_sel(input logic [1:0] se, input logic [1:0] sd);
    fwd_be_rs1_exe = se; fwd_be_rs2_exe = se; fwd_be_rs1_dec = sd; fwd_be_rs2_dec = sd;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        stall, bubble, flush;
    logic [4:0]  rd;
    logic        we, pwe;
    logic [31:0] res, resp;
    logic [1:0]  sel_e, sel_d;
    logic [4:0]  e_rd_mem;
    logic        e_we_mem;
    logic [4:0]  e_rd_wbk;
    logic        e_rf_we, e_rfp_we;
    logic [31:0] e_wdata, e_fwd_e, e_fwd_d;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkv(
    input logic st, input logic bu, input logic fl, input logic [4:0] rd, input logic we,
    input logic pwe, input logic [31:0] res, input logic [31:0] resp, input logic [1:0] se,
    input logic [1:0] sd, input logic [4:0] erm, input logic ewm, input logic [4:0] erw,
    input logic erf, input logic erfp, input logic [31:0] ewd, input logic [31:0] efe,
    input logic [31:0] efd);
    vec_t v;
    v.stall = st; v.bubble = bu; v.flush = fl; v.rd = rd; v.we = we; v.pwe = pwe;
    v.res = res; v.resp = resp; v.sel_e = se; v.sel_d = sd;
    v.e_rd_mem = erm; v.e_we_mem = ewm; v.e_rd_wbk = erw; v.e_rf_we = erf; v.e_rfp_we = erfp;
    v.e_wdata = ewd; v.e_fwd_e = efe; v.e_fwd_d = efd;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        we, pwe, ld, ml;
    logic [31:0] d, pd;
  } instr_t;

  instr_t in_mem, in_wbk;

  function automatic logic [31:0] mem_word(input logic hi);
    if (in_mem.ld || in_mem.ml) return hi ? late_resp_mem : late_res_mem;
    return hi ? in_mem.pd : in_mem.d;
  endfunction

  function automatic logic [31:0] src_exe(input logic [1:0] sel);
    if (sel[0]) return sel[1] ? in_wbk.pd : in_wbk.d;
    return mem_word(sel[1]);
  endfunction

  task automatic model_check();
    logic waiting;
    waiting = (in_mem.ld || in_mem.ml) && !late_valid_mem;
    chk("rd_mem", 32'(rd_mem), 32'(in_mem.rd));
    chk("rd_we_mem", 32'(rd_we_mem), 32'(in_mem.we));
    chk("rdp_we_mem", 32'(rdp_we_mem), 32'(in_mem.pwe));
    chk("load_inst_mem", 32'(load_inst_mem), 32'(in_mem.ld));
    chk("mult_inst_mem", 32'(mult_inst_mem), 32'(in_mem.ml));
    chk("rd_wbk", 32'(rd_wbk), 32'(in_wbk.rd));
    chk("rd_we_wbk", 32'(rd_we_wbk), 32'(in_wbk.we));
    chk("rdp_we_wbk", 32'(rdp_we_wbk), 32'(in_wbk.pwe));
    chk("rf_we", 32'(rf_we), 32'(in_wbk.we && in_wbk.rd != 5'd0));
    chk("rfp_we", 32'(rfp_we), 32'(in_wbk.pwe));
    chk("rf_wdata", rf_wdata, in_wbk.d);
    chk("rfp_wdata", rfp_wdata, in_wbk.pd);
    chk("late_wait", 32'(late_wait), 32'(waiting));
    chk("fwd_rs1_exe", fwd_rs1_exe, src_exe(fwd_be_rs1_exe));
    chk("fwd_rs2_exe", fwd_rs2_exe, src_exe(fwd_be_rs2_exe));
    chk("fwd_rs1_dec", fwd_rs1_dec, fwd_be_rs1_dec[1] ? in_wbk.pd : in_wbk.d);
    chk("fwd_rs2_dec", fwd_rs2_dec, fwd_be_rs2_dec[1] ? in_wbk.pd : in_wbk.d);
  endtask

  // An instruction retires from MEM only when the pipe moves; its result is settled then
  task automatic model_clock();
    logic moves;
    moves = !stall && !((in_mem.ld || in_mem.ml) && !late_valid_mem);
    if (moves) begin
      in_wbk    = in_mem;
      in_wbk.d  = mem_word(1'b0);
      in_wbk.pd = mem_word(1'b1);
      if (flush_exe || bubble_exe) in_mem = '{default: '0};
      else in_mem = '{rd_exe, rd_we_exe, rdp_we_exe, load_inst_exe, mult_inst_exe,
                      res_exe, resp_exe};
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; flush_exe = 0; bubble_exe = 0; late_valid_mem = 0;
    late_res_mem = 0; late_resp_mem = 0;
    set_exe(5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
    set_sel(2'd0, 2'd0);

    //                 st bu fl rd we pw res    resp   se sd  erm ewm erw rf rfp wdata  fwd_e  fwd_d
    vecs[0]  = mkv(0, 0, 0, 5,  1, 0, 32'h11, 32'h0, 0, 0,  5,  1,  0, 0, 0, 32'h0,  32'h11, 32'h0);
    vecs[1]  = mkv(0, 0, 0, 6,  1, 0, 32'h22, 32'h0, 0, 0,  6,  1,  5, 1, 0, 32'h11, 32'h22, 32'h11);
    vecs[2]  = mkv(0, 0, 0, 3,  1, 0, 32'hA,  32'hB, 1, 0,  3,  1,  6, 1, 0, 32'h22, 32'h22, 32'h22);
    vecs[3]  = mkv(0, 0, 0, 4,  1, 1, 32'hC,  32'hD, 0, 0,  4,  1,  3, 1, 0, 32'hA,  32'hC,  32'hA);
    vecs[4]  = mkv(0, 0, 0, 8,  1, 0, 32'hA,  32'hB, 0, 0,  8,  1,  4, 1, 1, 32'hC,  32'hA,  32'hC);
    vecs[5]  = mkv(1, 0, 0, 9,  1, 0, 32'h99, 32'h0, 1, 1,  8,  1,  4, 1, 1, 32'hC,  32'hC,  32'hC);
    vecs[6]  = mkv(1, 0, 0, 9,  1, 0, 32'h99, 32'h0, 2, 2,  8,  1,  4, 1, 1, 32'hC,  32'hB,  32'hD);
    vecs[7]  = mkv(1, 0, 0, 9,  1, 0, 32'h99, 32'h0, 3, 3,  8,  1,  4, 1, 1, 32'hC,  32'hD,  32'hD);
    vecs[8]  = mkv(1, 0, 1, 9,  1, 0, 32'h99, 32'h0, 0, 0,  8,  1,  4, 1, 1, 32'hC,  32'hA,  32'hC);
    vecs[9]  = mkv(0, 1, 0, 9,  1, 1, 32'h99, 32'h0, 0, 0,  0,  0,  8, 1, 0, 32'hA,  32'h0,  32'hA);
    vecs[10] = mkv(0, 0, 1, 9,  1, 0, 32'h77, 32'h0, 0, 0,  0,  0,  0, 0, 0, 32'h0,  32'h0,  32'h0);
    vecs[11] = mkv(0, 0, 0, 0,  1, 0, 32'h33, 32'h0, 0, 0,  0,  1,  0, 0, 0, 32'h0,  32'h33, 32'h0);
    vecs[12] = mkv(0, 0, 0, 1,  0, 0, 32'h0,  32'h0, 0, 0,  1,  0,  0, 0, 0, 32'h33, 32'h0,  32'h33);
    vecs[13] = mkv(0, 1, 1, 2,  1, 0, 32'h5,  32'h0, 0, 0,  0,  0,  1, 0, 0, 32'h0,  32'h0,  32'h0);

    #3;
    chk("reset rd_mem", 32'(rd_mem), 32'h0);
    chk("reset rf_we", 32'(rf_we), 32'h0);
    chk("reset late_wait", 32'(late_wait), 32'h0);
    chk("reset fwd_rs1_exe", fwd_rs1_exe, 32'h0);
    chk("reset rf_wdata", rf_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; bubble_exe = vecs[i].bubble; flush_exe = vecs[i].flush;
      set_exe(vecs[i].rd, vecs[i].we, vecs[i].pwe, 0, 0, vecs[i].res, vecs[i].resp);
      set_sel(vecs[i].sel_e, vecs[i].sel_d);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d rd_mem", i), 32'(rd_mem), 32'(vecs[i].e_rd_mem));
      chk($sformatf("v%0d rd_we_mem", i), 32'(rd_we_mem), 32'(vecs[i].e_we_mem));
      chk($sformatf("v%0d rd_wbk", i), 32'(rd_wbk), 32'(vecs[i].e_rd_wbk));
      chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_rf_we));
      chk($sformatf("v%0d rfp_we", i), 32'(rfp_we), 32'(vecs[i].e_rfp_we));
      chk($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d fwd_rs1_exe", i), fwd_rs1_exe, vecs[i].e_fwd_e);
      chk($sformatf("v%0d fwd_rs2_exe", i), fwd_rs2_exe, vecs[i].e_fwd_e);
      chk($sformatf("v%0d fwd_rs1_dec", i), fwd_rs1_dec, vecs[i].e_fwd_d);
      chk($sformatf("v%0d fwd_rs2_dec", i), fwd_rs2_dec, vecs[i].e_fwd_d);
    end

    // Load with a 2-cycle late result
    stall = 0; bubble_exe = 0; flush_exe = 0; set_sel(2'd0, 2'd0);
    set_exe(5'd7, 1, 0, 1, 0, 32'hDEAD, 32'h0);
    @(posedge clk); @(negedge clk);
    set_exe(5'd12, 1, 0, 0, 0, 32'h44, 32'h0);
    #1;
    chk("load late_wait c1", 32'(late_wait), 32'h1);
    chk("load load_inst_mem", 32'(load_inst_mem), 32'h1);
    @(posedge clk); @(negedge clk);
    #1;
    chk("load late_wait c2", 32'(late_wait), 32'h1);
    chk("load frozen rd_mem", 32'(rd_mem), 32'd7);
    chk("load frozen rd_we_wbk", 32'(rd_we_wbk), 32'h0);
    late_valid_mem = 1; late_res_mem = 32'h55; late_resp_mem = 32'h66;
    #1;
    chk("load late_wait released", 32'(late_wait), 32'h0);
    chk("load fwd mem late", fwd_rs1_exe, 32'h55);
    @(posedge clk); @(negedge clk);
    late_valid_mem = 0;
    #1;
    chk("load rf_we", 32'(rf_we), 32'h1);
    chk("load rd_wbk", 32'(rd_wbk), 32'd7);
    chk("load rf_wdata", rf_wdata, 32'h55);
    chk("load next rd_mem", 32'(rd_mem), 32'd12);

    // Paired mult write
    set_exe(5'd10, 1, 1, 0, 1, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    set_exe(5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
    late_valid_mem = 1; late_res_mem = 32'h1; late_resp_mem = 32'h2;
    @(posedge clk); @(negedge clk);
    late_valid_mem = 0;
    #1;
    chk("mult rd_wbk", 32'(rd_wbk), 32'd10);
    chk("mult rf_we", 32'(rf_we), 32'h1);
    chk("mult rfp_we", 32'(rfp_we), 32'h1);
    chk("mult rf_wdata", rf_wdata, 32'h1);
    chk("mult rfp_wdata", rfp_wdata, 32'h2);

    // Reset asserted while waiting on a late result
    set_exe(5'd13, 1, 0, 1, 0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    set_exe(5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
    late_res_mem = 32'h999;
    #1;
    chk("rst pre late_wait", 32'(late_wait), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst late_wait", 32'(late_wait), 32'h0);
    chk("rst rd_mem", 32'(rd_mem), 32'h0);
    chk("rst rf_we", 32'(rf_we), 32'h0);
    chk("rst rfp_we", 32'(rfp_we), 32'h0);
    chk("rst rf_wdata", rf_wdata, 32'h0);
    chk("rst fwd_rs1_exe", fwd_rs1_exe, 32'h0);
    chk("rst fwd_rs1_dec", fwd_rs1_dec, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_mem = '{default: '0};
    in_wbk = '{default: '0};

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall      = ($urandom % 5) == 0;
      flush_exe  = ($urandom % 8) == 0;
      bubble_exe = ($urandom % 8) == 0;
      rd_exe        = 5'($urandom);
      rd_we_exe     = 1'($urandom);
      rdp_we_exe    = 1'($urandom);
      load_inst_exe = ($urandom % 4) == 0;
      mult_inst_exe = !load_inst_exe && (($urandom % 5) == 0);
      res_exe       = $urandom;
      resp_exe      = $urandom;
      late_valid_mem = 1'($urandom);
      late_res_mem   = $urandom;
      late_resp_mem  = $urandom;
      fwd_be_rs1_exe = 2'($urandom);
      fwd_be_rs2_exe = 2'($urandom);
      fwd_be_rs1_dec = 2'($urandom);
      fwd_be_rs2_dec = 2'($urandom);
      #1;
      model_check();
      @(posedge clk);
      model_clock();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ama_riscv_result_pipe.md
# ama_riscv_result_pipe

Producer side of operand forwarding. Carries each instruction's destination info (`rd`, `rd_we`, `rdp_we`) and its result words from EXE through MEM to WBK. Supplies the forwarding unit with MEM/WBK destination state and returns forwarded data for the mux codes the unit selects. Also drives the register-file write port(s) and absorbs late results from 2-cycle instructions (load, mult) that arrive in MEM.

## Interface
Parameters:
- `XLEN`, 32, data word width

Ports:
- `clk` in 1: core clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `stall` in 1: global pipeline freeze (fetch/dmem backpressure)
- `flush_exe` in 1: kill instruction leaving EXE (branch mispredict)
- `bubble_exe` in 1: `hazard.to_exe` from forwarding unit; insert bubble into MEM
- `rd_exe` in `rf_addr_t`: destination register
- `rd_we_exe`, `rdp_we_exe` in 1 each: rd / paired-rd write enables
- `load_inst_exe`, `mult_inst_exe` in 1 each: 2-cycle instruction class
- `res_exe` in XLEN: ALU result (low word)
- `resp_exe` in XLEN: paired (high) result word
- `late_res_mem`, `late_resp_mem` in XLEN: load/mult result words, valid in MEM
- `late_valid_mem` in 1: late result present this cycle
- `fwd_be_rs1_exe`, `fwd_be_rs2_exe` in `fwd_be_t`: EXE forward select
- `fwd_be_rs1_dec`, `fwd_be_rs2_dec` in `fwd_be_t`: DEC forward select
- `rd_mem`, `rd_wbk` out `rf_addr_t`: stage destinations
- `rd_we_mem`, `rdp_we_mem`, `rd_we_wbk`, `rdp_we_wbk` out 1 each
- `load_inst_mem`, `mult_inst_mem` out 1 each
- `fwd_rs1_exe`, `fwd_rs2_exe`, `fwd_rs1_dec`, `fwd_rs2_dec` out XLEN: forwarded data
- `rf_we`, `rfp_we` out 1 each: register-file writes to `rd_wbk` / `get_rdp(rd_wbk)`
- `rf_wdata`, `rfp_wdata` out XLEN
- `late_wait` out 1: 2-cycle result not yet valid; core must stall

## Operation
- Two stage registers, MEM and WBK. Each holds rd, rd_we, rdp_we, load/mult flags, and data/pdata.
- `rdp` address comes from shared `get_rdp()`. It is the same function the forwarding unit uses, so both ends agree.
- `fwd_be_t` encoding is {rdp, wbk}:
  - 00: MEM data
  - 01: WBK data
  - 10: MEM pdata
  - 11: WBK pdata
- DEC selects ignore bit0 and always read the WBK word.
- MEM effective data:
  - If `load_inst_mem|mult_inst_mem`: `late_res_mem`/`late_resp_mem`.
  - Otherwise: the registered `res`/`resp`.
- MEM-sourced forwarding of a 2-cycle instruction is never requested (the unit raises `bubble_exe`). The mux still returns effective MEM data.
- `late_wait = (load_inst_mem|mult_inst_mem) & ~late_valid_mem`.
- Advance enable `adv = ~stall & ~late_wait`.
- On `adv`:
  - WBK <= MEM, with MEM effective data captured.
  - MEM <= EXE fields. If `flush_exe|bubble_exe`, all MEM enables and class flags are cleared; rd and data are don't-care and stay 0.
- When `~adv`, both stages hold. A held WBK re-asserts the same RF write (idempotent).
- `rf_we = rd_we_wbk & (rd_wbk != RF_X0_ZERO)`. `rfp_we = rdp_we_wbk`. Write data is taken from WBK.

## Timing
- Reset (async assert, sync release): all stage fields 0. Every output is 0, including `late_wait`, `rf_we` and all forward data.
- Latency: EXE to MEM visible 1 cycle after `adv`; WBK the next cycle. RF written in the WBK cycle, 2 cycles after EXE.
- Forward outputs are purely combinational from stage registers, the late inputs and the select codes. No added cycle.
- Simultaneous `flush_exe` and `bubble_exe`: bubble (identical effect).
- `stall` with `flush_exe`: nothing moves. Flush is ignored while `adv`=0, so the source must hold it until accepted.
- `late_valid_mem` without a 2-cycle instruction in MEM: ignored.
- Reset asserted mid-stall or mid-`late_wait`: stages clear immediately. `late_wait` drops asynchronously.

## Test plan
- Back-to-back ALU: EXE `rd=5 res=0x11`, next `rd=6 res=0x22` -> cycle+1 `rd_mem=5`; cycle+2 `rf_we=1`, `rf_addr=5`, `rf_wdata=0x11`, then `rd=6`/`0x22`.
- Forward codes: MEM `res=0xA`, `resp=0xB`; WBK `data=0xC`, `pdata=0xD`. Selects 00/01/10/11 -> `fwd_rs1_exe` = 0xA/0xC/0xB/0xD. A DEC select of 10 returns 0xD.
- Load late result: `load_inst_exe rd=7`, `late_valid_mem=0` for 2 cycles then 1 with `0x55` -> `late_wait` high 2 cycles with stages frozen. Then WBK `rf_wdata=0x55`, `rd=7`.
- Bubble/flush: `bubble_exe=1` with EXE `rd=9 we=1` -> next cycle `rd_we_mem=0`, `rdp_we_mem=0`. WBK advances normally.
- Paired write: mult `rd=10`, `rd_we=rdp_we=1`, late `0x1`/`0x2` -> WBK `rf_we=rfp_we=1`, `rf_wdata=0x1`, `rfp_wdata=0x2`.
- x0 and reset: `rd=0 we=1` -> `rf_we=0`. Assert `rst_n=0` during `late_wait` -> all outputs 0 immediately.
